// File: rtl/can_error_controller.sv
// CAN error confinement (TEC/REC, active/passive/bus-off, bus-off recovery) and error-frame sequencer.
// Optional macro CAN_ERR_WARN_EN adds a registered ERR_WARN output (TEC or REC at or above 96).
module can_error_controller #(
   parameter int FLAG_LEN      = 6,
   parameter int DELIM_LEN     = 8,
   parameter int PASSIVE_LIMIT = 128,
   parameter int RECOVERY_SEQ  = 128
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       SP,
   input  logic       RX_BIT,
   input  logic       TX_MODE,
   input  logic       STF_E,
   input  logic       EOF_E,
   input  logic       CRC_E,
   input  logic       FRM_E,
   input  logic       RX_OK,
   input  logic       TX_OK,
   output logic       TX_BIT,
   output logic       ERR_FRAME,
   output logic [1:0] ERR_STATE,
   output logic [8:0] TEC,
   output logic [7:0] REC
`ifdef CAN_ERR_WARN_EN
   ,
   output logic       ERR_WARN
`endif
);

   localparam int FW = $clog2(FLAG_LEN + 1);
   localparam int DW = $clog2(DELIM_LEN + 1);
   localparam int SW = $clog2(RECOVERY_SEQ + 1);
   localparam logic [FW-1:0] FLAG_LAST  = FW'(FLAG_LEN - 1);
   localparam logic [DW-1:0] DELIM_LAST = DW'(DELIM_LEN - 1);
   localparam logic [SW-1:0] SEQ_LAST   = SW'(RECOVERY_SEQ - 1);
   localparam logic [8:0]    PASS_LIM   = 9'(PASSIVE_LIMIT);

   localparam logic [1:0] ST_ACTIVE  = 2'b00;
   localparam logic [1:0] ST_PASSIVE = 2'b01;
   localparam logic [1:0] ST_BUSOFF  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLAG,
      S_DELIM,
      S_BUSOFF
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [FW-1:0] r_flag_cnt;
   logic [DW-1:0] r_delim_cnt;
   logic [3:0]    r_run_cnt;
   logic [SW-1:0] r_seq_cnt;
   logic [8:0]    r_tec;
   logic [7:0]    r_rec;
   logic [1:0]    r_err_state;

   logic w_err_flag;
   logic w_err_evt;
   logic w_ok_window;
   logic w_busoff_hit;
   logic w_flag_done;
   logic w_delim_done;
   logic w_run_done;
   logic w_recovered;

   assign w_err_flag   = ~(STF_E & EOF_E & CRC_E & FRM_E);
   assign w_err_evt    = SP & w_err_flag & (r_state == S_IDLE) & (r_err_state != ST_BUSOFF);
   assign w_ok_window  = SP & (r_state == S_IDLE);
   assign w_busoff_hit = (r_tec >= 9'd256);
   assign w_flag_done  = SP & (r_state == S_FLAG) & (r_flag_cnt == FLAG_LAST);
   assign w_delim_done = SP & (r_state == S_DELIM) & RX_BIT & (r_delim_cnt == DELIM_LAST);
   assign w_run_done   = SP & (r_state == S_BUSOFF) & RX_BIT & (r_run_cnt == 4'd10);
   assign w_recovered  = w_run_done & (r_seq_cnt == SEQ_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_err_evt)    w_next_state = S_FLAG;
         S_FLAG:   if (w_flag_done)  w_next_state = S_DELIM;
         S_DELIM:  if (w_delim_done) w_next_state = S_IDLE;
         S_BUSOFF: if (w_recovered)  w_next_state = S_IDLE;
         default:                    w_next_state = S_IDLE;
      endcase
      // A saturated TEC pre-empts whatever frame activity is in progress.
      if (w_busoff_hit && (r_state != S_BUSOFF)) w_next_state = S_BUSOFF;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_flag_cnt  <= '0;
         r_delim_cnt <= '0;
      end else begin
         if (r_state != S_FLAG)  r_flag_cnt <= '0;
         else if (SP)            r_flag_cnt <= w_flag_done ? '0 : r_flag_cnt + 1'b1;
         if (r_state != S_DELIM) r_delim_cnt <= '0;
         else if (SP)            r_delim_cnt <= (!RX_BIT || w_delim_done) ? '0 : r_delim_cnt + 1'b1;
      end
   end

   // Recovery: runs of 11 recessive bits; a dominant bit restarts only the current run.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_run_cnt <= '0;
         r_seq_cnt <= '0;
      end else if (r_state != S_BUSOFF) begin
         r_run_cnt <= '0;
         r_seq_cnt <= '0;
      end else if (SP) begin
         if (!RX_BIT) begin
            r_run_cnt <= '0;
         end else if (w_run_done) begin
            r_run_cnt <= '0;
            r_seq_cnt <= w_recovered ? '0 : r_seq_cnt + 1'b1;
         end else begin
            r_run_cnt <= r_run_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tec <= '0;
         r_rec <= '0;
      end else if (w_recovered) begin
         r_tec <= '0;
         r_rec <= '0;
      end else if (w_err_evt) begin
         if (TX_MODE)              r_tec <= (r_tec >= 9'd248) ? 9'd256 : r_tec + 9'd8;
         else if (r_rec != 8'hFF)  r_rec <= r_rec + 8'd1;
      end else if (w_ok_window) begin
         if (RX_OK) begin
            if (r_rec > 8'd127)     r_rec <= 8'd119;
            else if (r_rec != 8'd0) r_rec <= r_rec - 8'd1;
         end
         if (TX_OK && (r_tec != 9'd0)) r_tec <= r_tec - 9'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                       r_err_state <= ST_ACTIVE;
      else if (w_recovered)                             r_err_state <= ST_ACTIVE;
      else if (w_busoff_hit)                            r_err_state <= ST_BUSOFF;
      else if ((r_tec >= PASS_LIM) || ({1'b0, r_rec} >= PASS_LIM)) r_err_state <= ST_PASSIVE;
      else                                              r_err_state <= ST_ACTIVE;
   end

`ifdef CAN_ERR_WARN_EN
   logic r_warn;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_warn <= 1'b0;
      else        r_warn <= (r_tec >= 9'd96) || (r_rec >= 8'd96);
   end
   assign ERR_WARN = r_warn;
`endif

   // Error-active nodes drive a dominant flag; passive nodes send it recessive.
   assign TX_BIT    = ~((r_state == S_FLAG) && (r_err_state == ST_ACTIVE));
   assign ERR_FRAME = (r_state == S_FLAG) || (r_state == S_DELIM);
   assign ERR_STATE = r_err_state;
   assign TEC       = r_tec;
   assign REC       = r_rec;

endmodule

// File: tb/tb_can_error_controller.sv
// Scoreboard bench for can_error_controller: per-bit reference model feeds an expectation queue,
// a monitor compares DUT outputs after each sample point.
module tb_can_error_controller;

   logic       clock;
   logic       reset;
   logic       SP, RX_BIT, TX_MODE, STF_E, EOF_E, CRC_E, FRM_E, RX_OK, TX_OK;
   logic       TX_BIT, ERR_FRAME;
   logic [1:0] ERR_STATE;
   logic [8:0] TEC;
   logic [7:0] REC;
`ifdef CAN_ERR_WARN_EN
   logic       ERR_WARN;
`endif

   can_error_controller dut (
      .clock(clock), .reset(reset), .SP(SP), .RX_BIT(RX_BIT), .TX_MODE(TX_MODE),
      .STF_E(STF_E), .EOF_E(EOF_E), .CRC_E(CRC_E), .FRM_E(FRM_E),
      .RX_OK(RX_OK), .TX_OK(TX_OK), .TX_BIT(TX_BIT), .ERR_FRAME(ERR_FRAME),
      .ERR_STATE(ERR_STATE), .TEC(TEC), .REC(REC)
`ifdef CAN_ERR_WARN_EN
      , .ERR_WARN(ERR_WARN)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int tx;
      int ef;
      int st;
      int tec;
      int rec;
      int warn;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   localparam int PH_IDLE = 0, PH_FLAG = 1, PH_DELIM = 2, PH_BUSOFF = 3;
   int m_tec, m_rec, m_phase, m_left, m_recess, m_seq;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lvl(input int t, input int r);
      if (t >= 256) return 2;
      if (t >= 128 || r >= 128) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_tec = 0; m_rec = 0; m_phase = PH_IDLE; m_left = 0; m_recess = 0; m_seq = 0;
   endtask

   task automatic model_step(input logic rx, input logic txm, input logic [3:0] errs,
                             input logic rxok, input logic txok);
      int l;
      l = lvl(m_tec, m_rec);
      if (m_phase == PH_IDLE) begin
         if (errs != 4'hF && l != 2) begin
            if (txm) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
            else     m_rec = (m_rec < 255) ? m_rec + 1 : 255;
            m_phase = PH_FLAG;
            m_left  = 6;
         end else begin
            if (rxok) begin
               if (m_rec > 127)    m_rec = 119;
               else if (m_rec > 0) m_rec = m_rec - 1;
            end
            if (txok && m_tec > 0) m_tec = m_tec - 1;
         end
      end else if (m_phase == PH_FLAG) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_phase  = PH_DELIM;
            m_recess = 0;
         end
      end else if (m_phase == PH_DELIM) begin
         m_recess = rx ? m_recess + 1 : 0;
         if (m_recess == 8) m_phase = PH_IDLE;
      end else begin
         if (rx) begin
            m_recess = m_recess + 1;
            if (m_recess == 11) begin
               m_recess = 0;
               m_seq    = m_seq + 1;
               if (m_seq == 128) begin
                  m_tec = 0; m_rec = 0; m_seq = 0; m_phase = PH_IDLE;
               end
            end
         end else begin
            m_recess = 0;
         end
      end
      if (m_tec >= 256 && m_phase != PH_BUSOFF) begin
         m_phase = PH_BUSOFF; m_recess = 0; m_seq = 0;
      end
   endtask

   // One bit time: SP high for one clock, then three idle clocks of random noise.
   task automatic sp(input logic rx, input logic txm, input logic [3:0] errs,
                     input logic rxok, input logic txok);
      exp_t e;
      @(negedge clock);
      RX_BIT = rx; TX_MODE = txm; {STF_E, EOF_E, CRC_E, FRM_E} = errs;
      RX_OK = rxok; TX_OK = txok; SP = 1'b1;
      model_step(rx, txm, errs, rxok, txok);
      e.tx   = (m_phase == PH_FLAG && lvl(m_tec, m_rec) == 0) ? 0 : 1;
      e.ef   = (m_phase == PH_FLAG || m_phase == PH_DELIM) ? 1 : 0;
      e.st   = lvl(m_tec, m_rec);
      e.tec  = m_tec;
      e.rec  = m_rec;
      e.warn = (m_tec >= 96 || m_rec >= 96) ? 1 : 0;
      q.push_back(e);
      @(negedge clock);
      SP = 1'b0;
      RX_BIT = 1'($urandom); TX_MODE = 1'($urandom);
      {STF_E, EOF_E, CRC_E, FRM_E} = 4'($urandom);
      RX_OK = 1'($urandom); TX_OK = 1'($urandom);
      repeat (2) @(negedge clock);
   endtask

   task automatic rand_sp();
      logic [3:0] errs;
      errs = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      sp(($urandom_range(0, 9) != 0), 1'($urandom), errs, 1'($urandom), 1'($urandom));
   endtask

   // Error frame: triggering bit, FLAG_LEN flag bits with noisy inputs, DELIM_LEN recessive bits.
   task automatic frame(input logic txm, input logic [3:0] errs);
      sp(1'b1, txm, errs, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) sp(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 8; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
      if (q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain: %0d expectations still pending, required 0", q.size());
      end
   endtask

   task automatic do_reset();
      drain();
      @(negedge clock);
      reset = 1'b0; SP = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_reset();
      q.delete();
   endtask

   // Monitor: every sample point is an output event; compare once counters and state have settled.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         if (SP && reset) begin
            @(negedge clock);
            @(negedge clock);
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sb_underflow: output event with no expectation queued");
            end else begin
               e = q.pop_front();
               chk("sb_TX_BIT", int'(TX_BIT), e.tx);
               chk("sb_ERR_FRAME", int'(ERR_FRAME), e.ef);
               chk("sb_ERR_STATE", int'(ERR_STATE), e.st);
               chk("sb_TEC", int'(TEC), e.tec);
               chk("sb_REC", int'(REC), e.rec);
`ifdef CAN_ERR_WARN_EN
               chk("sb_ERR_WARN", int'(ERR_WARN), e.warn);
`endif
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset = 1'b0; SP = 1'b0; RX_BIT = 1'b1; TX_MODE = 1'b0;
      STF_E = 1'b1; EOF_E = 1'b1; CRC_E = 1'b1; FRM_E = 1'b1; RX_OK = 1'b0; TX_OK = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      chk("rst_TX_BIT", int'(TX_BIT), 1);
      chk("rst_ERR_FRAME", int'(ERR_FRAME), 0);
      chk("rst_ERR_STATE", int'(ERR_STATE), 0);
      chk("rst_TEC", int'(TEC), 0);
      chk("rst_REC", int'(REC), 0);
`ifdef CAN_ERR_WARN_EN
      chk("rst_ERR_WARN", int'(ERR_WARN), 0);
`endif
      reset = 1'b1;

      // Receive error (stuff error) with a clean delimiter.
      frame(1'b0, 4'b0111);
      drain();
      chk("rx_err_REC", int'(REC), 1);
      chk("rx_err_frame_done", int'(ERR_FRAME), 0);

      // Delimiter restart: 1,1,1,0 then eight recessive bits.
      sp(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      sp(1'b0, 1'b0, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      drain();
      chk("delim_restart_hold", int'(ERR_FRAME), 1);
      sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      drain();
      chk("delim_restart_close", int'(ERR_FRAME), 0);

      // Receive errors up to REC=130, then the clamp and error-vs-OK priority.
      for (int i = 0; i < 128; i++) begin
         frame(1'b0, 4'($urandom_range(0, 14)));
`ifdef CAN_ERR_WARN_EN
         if (m_rec == 96) begin
            drain();
            chk("warn_at_rec96", int'(ERR_WARN), 1);
         end
`endif
      end
      drain();
      chk("rec130_REC", int'(REC), 130);
      chk("rec130_passive", int'(ERR_STATE), 1);
      sp(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
      drain();
      chk("rec_clamp_119", int'(REC), 119);
      sp(1'b1, 1'b0, 4'b1110, 1'b1, 1'b0);
      drain();
      chk("prio_REC", int'(REC), 120);
      chk("prio_ERR_FRAME", int'(ERR_FRAME), 1);
      for (int i = 0; i < 14; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);

      // Transmit errors to passive, passive flag, then bus-off and recovery.
      do_reset();
      for (int i = 0; i < 16; i++) frame(1'b1, 4'b1101);
      drain();
      chk("tx16_TEC", int'(TEC), 128);
      chk("tx16_passive", int'(ERR_STATE), 1);
      sp(1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
         if (i < 5) chk("passive_flag_recessive", int'(TX_BIT), 1);
      end
      for (int i = 0; i < 8; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) frame(1'b1, 4'b1101);
      sp(1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
      drain();
      chk("busoff_TEC", int'(TEC), 256);
      chk("busoff_state", int'(ERR_STATE), 2);
      chk("busoff_TX_BIT", int'(TX_BIT), 1);
      chk("busoff_no_frame", int'(ERR_FRAME), 0);
      for (int i = 0; i < 5; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      sp(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 128 * 11 - 1; i++) sp(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      drain();
      chk("busoff_not_yet", int'(ERR_STATE), 2);
      sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      drain();
      chk("recovered_TEC", int'(TEC), 0);
      chk("recovered_REC", int'(REC), 0);
      chk("recovered_state", int'(ERR_STATE), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) rand_sp();

      // Async reset in the middle of an error flag.
      if (m_phase == PH_BUSOFF) do_reset();
      for (int i = 0; i < 40; i++) begin
         if (m_phase == PH_IDLE) break;
         sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      end
      sp(1'b1, 1'b1, 4'b1110, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) sp(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
      drain();
      chk("pre_reset_frame", int'(ERR_FRAME), 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("async_TX_BIT", int'(TX_BIT), 1);
      chk("async_ERR_FRAME", int'(ERR_FRAME), 0);
      chk("async_TEC", int'(TEC), 0);
      chk("async_REC", int'(REC), 0);
      chk("async_ERR_STATE", int'(ERR_STATE), 0);
`ifdef CAN_ERR_WARN_EN
      chk("async_ERR_WARN", int'(ERR_WARN), 0);
`endif
      repeat (2) @(negedge clock);
      reset = 1'b1;
      model_reset();
      q.delete();
      for (int i = 0; i < 20; i++) rand_sp();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
